idma_inst64_decoder: RTL and testbench

IDMA_INST64_DECODER -- requirements
Module: idma_inst64_decoder

---
 rtl/idma_inst64_snitch_pkg.sv | 47 ++++
 rtl/idma_inst64_decoder_if.sv | 50 +++++
 rtl/idma_inst64_decoder.sv | 156 +++++++++++++++
 tb/tb_idma_inst64_decoder.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/idma_inst64_snitch_pkg.sv
// rtl/idma_inst64_snitch_pkg.sv - Snitch iDMA instruction encodings, status selectors and op decode
// Exports: DM* wildcard encodings, STAT_* selector constants, op_e and decode_op().
package idma_inst64_snitch_pkg;

    // Wildcard encodings: funct7 | rs2 | rs1 | funct3 | rd | opcode
    localparam logic [31:0] DMSRC   = 32'b0000000_?????_?????_000_00000_0101011;
    localparam logic [31:0] DMDST   = 32'b0000001_?????_?????_000_00000_0101011;
    localparam logic [31:0] DMCPYI  = 32'b0000010_?????_?????_000_?????_0101011;
    localparam logic [31:0] DMCPY   = 32'b0000011_?????_?????_000_?????_0101011;
    localparam logic [31:0] DMSTATI = 32'b0000100_?????_00000_000_?????_0101011;
    localparam logic [31:0] DMSTAT  = 32'b0000101_?????_00000_000_?????_0101011;
    localparam logic [31:0] DMSTR   = 32'b0000110_?????_?????_000_00000_0101011;
    localparam logic [31:0] DMREP   = 32'b0000111_00000_?????_000_00000_0101011;
    localparam logic [31:0] DMMCAST = 32'b0001000_00000_?????_000_00000_0101011;

    // Status selectors for DMSTATI / DMSTAT
    localparam logic [4:0] STAT_DONE = 5'd0;
    localparam logic [4:0] STAT_NEXT = 5'd1;
    localparam logic [4:0] STAT_BUSY = 5'd2;

    typedef enum logic [3:0] {
        OP_SRC,
        OP_DST,
        OP_CPYI,
        OP_CPY,
        OP_STATI,
        OP_STAT,
        OP_STR,
        OP_REP,
        OP_MCAST,
        OP_ILLEGAL
    } op_e;

    function automatic op_e decode_op(input logic [31:0] op);
        if (op ==? DMSRC)   return OP_SRC;
        if (op ==? DMDST)   return OP_DST;
        if (op ==? DMCPYI)  return OP_CPYI;
        if (op ==? DMCPY)   return OP_CPY;
        if (op ==? DMSTATI) return OP_STATI;
        if (op ==? DMSTAT)  return OP_STAT;
        if (op ==? DMSTR)   return OP_STR;
        if (op ==? DMREP)   return OP_REP;
        if (op ==? DMMCAST) return OP_MCAST;
        return OP_ILLEGAL;
    endfunction

endpackage

// File: rtl/idma_inst64_decoder_if.sv
// rtl/idma_inst64_decoder_if.sv - offload request, writeback and DMA transfer-request bundle
// slave : decoder side (accepts acc_req_*, drives acc_rsp_* and dma_*)
// master: core / back-end side
interface idma_inst64_decoder_if #(
    parameter int unsigned AddrWidth = 48
);
    logic                 acc_req_valid_i;
    logic                 acc_req_ready_o;
    logic [31:0]          acc_req_op_i;
    logic [31:0]          acc_req_arga_i;
    logic [31:0]          acc_req_argb_i;
    logic [4:0]           acc_req_rd_i;

    logic                 acc_rsp_valid_o;
    logic                 acc_rsp_ready_i;
    logic [31:0]          acc_rsp_data_o;
    logic [4:0]           acc_rsp_rd_o;

    logic                 dma_req_valid_o;
    logic                 dma_req_ready_i;
    logic [AddrWidth-1:0] dma_src_o;
    logic [AddrWidth-1:0] dma_dst_o;
    logic [31:0]          dma_len_o;
    logic [31:0]          dma_src_stride_o;
    logic [31:0]          dma_dst_stride_o;
    logic [31:0]          dma_reps_o;
    logic [31:0]          dma_mcast_o;
    logic                 dma_decouple_o;
    logic                 dma_2d_o;

    modport slave (
        input  acc_req_valid_i, acc_req_op_i, acc_req_arga_i, acc_req_argb_i, acc_req_rd_i,
        output acc_req_ready_o,
        output acc_rsp_valid_o, acc_rsp_data_o, acc_rsp_rd_o,
        input  acc_rsp_ready_i,
        output dma_req_valid_o, dma_src_o, dma_dst_o, dma_len_o, dma_src_stride_o,
        output dma_dst_stride_o, dma_reps_o, dma_mcast_o, dma_decouple_o, dma_2d_o,
        input  dma_req_ready_i
    );

    modport master (
        output acc_req_valid_i, acc_req_op_i, acc_req_arga_i, acc_req_argb_i, acc_req_rd_i,
        input  acc_req_ready_o,
        input  acc_rsp_valid_o, acc_rsp_data_o, acc_rsp_rd_o,
        output acc_rsp_ready_i,
        input  dma_req_valid_o, dma_src_o, dma_dst_o, dma_len_o, dma_src_stride_o,
        input  dma_dst_stride_o, dma_reps_o, dma_mcast_o, dma_decouple_o, dma_2d_o,
        output dma_req_ready_i
    );
endinterface

// File: rtl/idma_inst64_decoder.sv
// rtl/idma_inst64_decoder.sv - decodes Snitch DMA instructions into transfer requests and writebacks
// clk_i/rst_i        : clock, asynchronous active-high reset
// bus (slave)        : offload request, writeback response, DMA transfer request
// next_id_i/done_id_i: back-end transfer IDs; busy_i: back-end busy
// illegal_o          : pulses in the cycle an unrecognised op is accepted
module idma_inst64_decoder
    import idma_inst64_snitch_pkg::*;
#(
    parameter int unsigned AddrWidth = 48,
    parameter int unsigned IdWidth   = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    idma_inst64_decoder_if.slave bus,
    input  logic [IdWidth-1:0]   next_id_i,
    input  logic [IdWidth-1:0]   done_id_i,
    input  logic                 busy_i,
    output logic                 illegal_o
);

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_e;

    state_e               state_q, state_d;
    logic                 alive_q;      // holds ready low until the first edge after reset
    logic                 accept;
    op_e                  op_kind;
    logic [31:0]          next_id32, done_id32, stat_val;
    logic [4:0]           stat_sel;
    logic                 cfg_dec, cfg_2d;
    logic [AddrWidth-1:0] src_q, dst_q;
    logic [31:0]          len_q, src_stride_q, dst_stride_q, reps_q, mcast_q, rsp_data_q;
    logic                 decouple_q, twod_q;
    logic [4:0]           rd_q;

    if (IdWidth >= 32) begin : g_id_trunc
        assign next_id32 = next_id_i[31:0];
        assign done_id32 = done_id_i[31:0];
    end else begin : g_id_ext
        assign next_id32 = {{(32-IdWidth){1'b0}}, next_id_i};
        assign done_id32 = {{(32-IdWidth){1'b0}}, done_id_i};
    end

    assign op_kind = decode_op(bus.acc_req_op_i);

    // Immediate forms take the selector/config from the rs2 field, register forms from argb.
    assign stat_sel = (op_kind == OP_STATI) ? bus.acc_req_op_i[24:20] : bus.acc_req_argb_i[4:0];
    assign cfg_dec  = (op_kind == OP_CPYI)  ? bus.acc_req_op_i[20]    : bus.acc_req_argb_i[0];
    assign cfg_2d   = (op_kind == OP_CPYI)  ? bus.acc_req_op_i[21]    : bus.acc_req_argb_i[1];

    always_comb begin
        stat_val = 32'd0;
        case (stat_sel)
            STAT_DONE: stat_val = done_id32;
            STAT_NEXT: stat_val = next_id32;
            STAT_BUSY: stat_val = {31'd0, busy_i};
            default:   stat_val = 32'd0;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            alive_q <= 1'b0;
        end else begin
            state_q <= state_d;
            alive_q <= 1'b1;
        end
    end

    always_comb begin
        state_d             = state_q;
        accept              = 1'b0;
        illegal_o           = 1'b0;
        bus.acc_req_ready_o = 1'b0;
        bus.dma_req_valid_o = 1'b0;
        bus.acc_rsp_valid_o = 1'b0;
        case (state_q)
            IDLE: begin
                bus.acc_req_ready_o = alive_q;
                if (alive_q && bus.acc_req_valid_i) begin
                    accept = 1'b1;
                    case (op_kind)
                        OP_CPYI, OP_CPY:   state_d = ISSUE;
                        OP_STATI, OP_STAT: state_d = RESP;
                        OP_ILLEGAL:        illegal_o = 1'b1;
                        default:           state_d = IDLE;
                    endcase
                end
            end
            ISSUE: begin
                bus.dma_req_valid_o = 1'b1;
                if (bus.dma_req_ready_i) state_d = RESP;
            end
            RESP: begin
                bus.acc_rsp_valid_o = 1'b1;
                if (bus.acc_rsp_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            src_q        <= '0;
            dst_q        <= '0;
            len_q        <= '0;
            src_stride_q <= '0;
            dst_stride_q <= '0;
            reps_q       <= '0;
            mcast_q      <= '0;
            decouple_q   <= 1'b0;
            twod_q       <= 1'b0;
            rd_q         <= '0;
            rsp_data_q   <= '0;
        end else begin
            if (accept) begin
                case (op_kind)
                    OP_SRC:   src_q <= AddrWidth'({bus.acc_req_argb_i, bus.acc_req_arga_i});
                    OP_DST:   dst_q <= AddrWidth'({bus.acc_req_argb_i, bus.acc_req_arga_i});
                    OP_STR: begin
                        src_stride_q <= bus.acc_req_arga_i;
                        dst_stride_q <= bus.acc_req_argb_i;
                    end
                    OP_REP:   reps_q  <= bus.acc_req_arga_i;
                    OP_MCAST: mcast_q <= bus.acc_req_arga_i;
                    OP_CPYI, OP_CPY: begin
                        len_q      <= bus.acc_req_arga_i;
                        decouple_q <= cfg_dec;
                        twod_q     <= cfg_2d;
                        rd_q       <= bus.acc_req_rd_i;
                    end
                    OP_STATI, OP_STAT: begin
                        rsp_data_q <= stat_val;
                        rd_q       <= bus.acc_req_rd_i;
                    end
                    default: ;
                endcase
            end
            // Writeback of a copy is the ID the back-end assigns on the handshake cycle.
            if (state_q == ISSUE && bus.dma_req_ready_i) rsp_data_q <= next_id32;
        end
    end

    assign bus.acc_rsp_data_o   = rsp_data_q;
    assign bus.acc_rsp_rd_o     = rd_q;
    assign bus.dma_src_o        = src_q;
    assign bus.dma_dst_o        = dst_q;
    assign bus.dma_len_o        = len_q;
    assign bus.dma_src_stride_o = src_stride_q;
    assign bus.dma_dst_stride_o = dst_stride_q;
    assign bus.dma_reps_o       = reps_q;
    assign bus.dma_mcast_o      = mcast_q;
    assign bus.dma_decouple_o   = decouple_q;
    assign bus.dma_2d_o         = twod_q;

endmodule

// File: tb/tb_idma_inst64_decoder.sv
// tb/tb_idma_inst64_decoder.sv - self-checking bench for idma_inst64_decoder
module tb_idma_inst64_decoder;

    localparam int AW = 48;
    localparam int IW = 32;
    localparam logic [63:0] AMASK = (64'd1 << AW) - 64'd1;

    localparam int K_SRC = 0, K_DST = 1, K_CPYI = 2, K_CPY = 3, K_STATI = 4;
    localparam int K_STAT = 5, K_STR = 6, K_REP = 7, K_MCAST = 8, K_ILL = 9;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [IW-1:0] next_id = '0;
    logic [IW-1:0] done_id = '0;
    logic          busy = 1'b0;
    logic          illegal;

    idma_inst64_decoder_if #(.AddrWidth(AW)) bus ();

    idma_inst64_decoder #(.AddrWidth(AW), .IdWidth(IW)) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .bus       (bus),
        .next_id_i (next_id),
        .done_id_i (done_id),
        .busy_i    (busy),
        .illegal_o (illegal)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: architectural configuration state of the DMA front end
    logic [63:0] m_src, m_dst;
    logic [31:0] m_len, m_ss, m_ds, m_reps, m_mcast;
    logic        m_dec, m_2d;

    function automatic void model_reset();
        m_src = 0; m_dst = 0; m_len = 0; m_ss = 0; m_ds = 0;
        m_reps = 0; m_mcast = 0; m_dec = 0; m_2d = 0;
    endfunction

    function automatic logic [31:0] stat_ref(input logic [4:0] sel);
        if (sel == 5'd0) return done_id;
        if (sel == 5'd1) return next_id;
        if (sel == 5'd2) return {31'd0, busy};
        return 32'd0;
    endfunction

    function automatic logic [31:0] mk_op(input int kind, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [4:0] rd);
        logic [4:0] f_rs2 = rs2, f_rs1 = rs1, f_rd = rd;
        if (kind == K_STATI || kind == K_STAT) f_rs1 = 5'd0;
        if (kind == K_SRC || kind == K_DST || kind == K_STR || kind == K_REP || kind == K_MCAST)
            f_rd = 5'd0;
        if (kind == K_REP || kind == K_MCAST) f_rs2 = 5'd0;
        return {7'(kind), f_rs2, f_rs1, 3'b000, f_rd, 7'h2B};
    endfunction

    task automatic check_req();
        check_eq("dma_src",      64'(bus.dma_src_o), m_src);
        check_eq("dma_dst",      64'(bus.dma_dst_o), m_dst);
        check_eq("dma_len",      64'(bus.dma_len_o), 64'(m_len));
        check_eq("dma_sstride",  64'(bus.dma_src_stride_o), 64'(m_ss));
        check_eq("dma_dstride",  64'(bus.dma_dst_stride_o), 64'(m_ds));
        check_eq("dma_reps",     64'(bus.dma_reps_o), 64'(m_reps));
        check_eq("dma_mcast",    64'(bus.dma_mcast_o), 64'(m_mcast));
        check_eq("dma_decouple", 64'(bus.dma_decouple_o), 64'(m_dec));
        check_eq("dma_2d",       64'(bus.dma_2d_o), 64'(m_2d));
    endtask

    // Presents one request; returns just after the accepting clock edge.
    task automatic send(input logic [31:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input bit exp_ill);
        bus.acc_req_valid_i = 1'b1;
        bus.acc_req_op_i    = op;
        bus.acc_req_arga_i  = a;
        bus.acc_req_argb_i  = b;
        bus.acc_req_rd_i    = rd;
        @(negedge clk);
        check_eq("req_ready", 64'(bus.acc_req_ready_o), 64'd1);
        check_eq("illegal", 64'(illegal), 64'(exp_ill));
        @(posedge clk); #1;
        bus.acc_req_valid_i = 1'b0;
        bus.acc_req_op_i    = $urandom;
        bus.acc_req_arga_i  = $urandom;
        bus.acc_req_argb_i  = $urandom;
    endtask

    task automatic rsp_phase(input logic [31:0] exp_data, input logic [4:0] exp_rd, input int stall);
        for (int i = 0; i <= stall; i++) begin
            bus.acc_rsp_ready_i = (i == stall);
            @(negedge clk);
            check_eq("rsp_valid", 64'(bus.acc_rsp_valid_o), 64'd1);
            check_eq("rsp_data", 64'(bus.acc_rsp_data_o), 64'(exp_data));
            check_eq("rsp_rd", 64'(bus.acc_rsp_rd_o), 64'(exp_rd));
            check_eq("rsp_no_dma", 64'(bus.dma_req_valid_o), 64'd0);
            check_eq("rsp_no_ready", 64'(bus.acc_req_ready_o), 64'd0);
            @(posedge clk); #1;
        end
        bus.acc_rsp_ready_i = 1'b0;
        @(negedge clk);
        check_eq("rsp_done", 64'(bus.acc_rsp_valid_o), 64'd0);
        check_eq("idle_ready", 64'(bus.acc_req_ready_o), 64'd1);
        @(posedge clk); #1;
    endtask

    task automatic run_op(input int kind, input logic [31:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd, input int s1,
                          input int s2, input logic [31:0] hs_id);
        logic [31:0] exp_rsp;
        logic [4:0]  cfg;
        logic [4:0]  sel;
        sel = (kind == K_STATI) ? op[24:20] : b[4:0];
        exp_rsp = stat_ref(sel);
        send(op, a, b, rd, kind == K_ILL);
        case (kind)
            K_SRC:   m_src = {b, a} & AMASK;
            K_DST:   m_dst = {b, a} & AMASK;
            K_STR:   begin m_ss = a; m_ds = b; end
            K_REP:   m_reps = a;
            K_MCAST: m_mcast = a;
            default: ;
        endcase
        if (kind == K_CPYI || kind == K_CPY) begin
            cfg   = (kind == K_CPYI) ? op[24:20] : b[4:0];
            m_len = a;
            m_dec = cfg[0];
            m_2d  = cfg[1];
            for (int i = 0; i <= s1; i++) begin
                bus.dma_req_ready_i = (i == s1);
                next_id = (i == s1) ? hs_id : $urandom;
                @(negedge clk);
                check_eq("dma_valid", 64'(bus.dma_req_valid_o), 64'd1);
                check_eq("issue_no_ready", 64'(bus.acc_req_ready_o), 64'd0);
                check_eq("issue_no_rsp", 64'(bus.acc_rsp_valid_o), 64'd0);
                check_req();
                @(posedge clk); #1;
            end
            bus.dma_req_ready_i = 1'b0;
            next_id = $urandom;
            rsp_phase(hs_id, rd, s2);
        end else if (kind == K_STATI || kind == K_STAT) begin
            done_id = $urandom;
            next_id = $urandom;
            busy    = 1'($urandom);
            rsp_phase(exp_rsp, rd, s2);
        end else begin
            @(negedge clk);
            check_eq("cfg_no_rsp", 64'(bus.acc_rsp_valid_o), 64'd0);
            check_eq("cfg_no_dma", 64'(bus.dma_req_valid_o), 64'd0);
            check_eq("illegal_pulse", 64'(illegal), 64'd0);
            check_eq("cfg_ready", 64'(bus.acc_req_ready_o), 64'd1);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        int kind;
        logic [31:0] a, b, op;
        logic [4:0]  imm, rd;

        bus.acc_req_valid_i = 1'b0;
        bus.acc_req_op_i    = '0;
        bus.acc_req_arga_i  = '0;
        bus.acc_req_argb_i  = '0;
        bus.acc_req_rd_i    = '0;
        bus.acc_rsp_ready_i = 1'b0;
        bus.dma_req_ready_i = 1'b0;
        model_reset();

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_ready", 64'(bus.acc_req_ready_o), 64'd0);
        check_eq("rst_rsp_valid", 64'(bus.acc_rsp_valid_o), 64'd0);
        check_eq("rst_dma_valid", 64'(bus.dma_req_valid_o), 64'd0);
        check_eq("rst_illegal", 64'(illegal), 64'd0);
        check_eq("rst_rsp_data", 64'(bus.acc_rsp_data_o), 64'd0);
        check_eq("rst_rsp_rd", 64'(bus.acc_rsp_rd_o), 64'd0);
        check_req();
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_eq("ready_after_rst", 64'(bus.acc_req_ready_o), 64'd1);
        @(posedge clk); #1;

        // Basic copy: src/dst, immediate copy, response = handshake ID
        run_op(K_SRC, mk_op(K_SRC, 5'd0, 5'd1, 5'd0), 32'h1000, 32'h1, 5'd0, 0, 0, 0);
        run_op(K_DST, mk_op(K_DST, 5'd0, 5'd2, 5'd0), 32'h2000, 32'h0, 5'd0, 0, 0, 0);
        run_op(K_CPYI, mk_op(K_CPYI, 5'd0, 5'd3, 5'd9), 32'd64, 32'd0, 5'd9, 0, 0, 32'd7);
        check_eq("req038_src", m_src, 64'h1_0000_1000);

        // 2D copy with sticky strides
        run_op(K_STR, mk_op(K_STR, 5'd4, 5'd5, 5'd0), 32'd8, 32'd16, 5'd0, 0, 0, 0);
        run_op(K_REP, mk_op(K_REP, 5'd0, 5'd6, 5'd0), 32'd4, 32'd0, 5'd0, 0, 0, 0);
        run_op(K_CPY, mk_op(K_CPY, 5'd7, 5'd8, 5'd3), 32'd32, 32'd2, 5'd3, 0, 1, 32'h55);
        run_op(K_CPY, mk_op(K_CPY, 5'd7, 5'd8, 5'd4), 32'd48, 32'd0, 5'd4, 0, 0, 32'h56);

        // Back-end stalls issue for 5 cycles
        run_op(K_CPY, mk_op(K_CPY, 5'd1, 5'd2, 5'd11), 32'd128, 32'd1, 5'd11, 5, 0, 32'hABCD);

        // Status reads, one with a stalled writeback
        done_id = 3; next_id = 9; busy = 1'b1;
        run_op(K_STATI, mk_op(K_STATI, 5'd0, 5'd0, 5'd12), 0, 0, 5'd12, 0, 0, 0);
        done_id = 3; next_id = 9; busy = 1'b1;
        run_op(K_STATI, mk_op(K_STATI, 5'd1, 5'd0, 5'd13), 0, 0, 5'd13, 0, 0, 0);
        done_id = 3; next_id = 9; busy = 1'b1;
        run_op(K_STATI, mk_op(K_STATI, 5'd2, 5'd0, 5'd14), 0, 0, 5'd14, 0, 3, 0);
        done_id = 3; next_id = 9; busy = 1'b1;
        run_op(K_STATI, mk_op(K_STATI, 5'd5, 5'd0, 5'd15), 0, 0, 5'd15, 0, 0, 0);

        // Unrecognised op
        run_op(K_ILL, 32'hFE00002B, 32'd1, 32'd2, 5'd0, 0, 0, 0);

        // Randomised mix
        for (int it = 0; it < 40; it++) begin
            kind = $urandom_range(0, 9);
            a    = $urandom;
            b    = $urandom;
            imm  = 5'($urandom);
            rd   = 5'($urandom);
            if (kind == K_STATI) imm = 5'($urandom_range(0, 4));
            if (kind == K_STAT) b[4:0] = 5'($urandom_range(0, 4));
            done_id = $urandom;
            next_id = $urandom;
            busy    = 1'($urandom);
            if (kind == K_ILL)
                op = {7'($urandom_range(9, 127)), 18'($urandom), 7'h2B};
            else
                op = mk_op(kind, imm, 5'($urandom), rd);
            run_op(kind, op, a, b, rd, $urandom_range(0, 3), $urandom_range(0, 3), $urandom);
        end

        // Reset during RESP aborts the writeback and clears the address registers
        send(mk_op(K_CPYI, 5'd0, 5'd1, 5'd4), 32'd16, 32'd0, 5'd4, 1'b0);
        bus.dma_req_ready_i = 1'b1;
        @(posedge clk); #1;
        bus.dma_req_ready_i = 1'b0;
        @(negedge clk);
        check_eq("pre_rst_rsp", 64'(bus.acc_rsp_valid_o), 64'd1);
        #1 rst = 1'b1;
        #1;
        check_eq("async_rsp_drop", 64'(bus.acc_rsp_valid_o), 64'd0);
        check_eq("async_ready_low", 64'(bus.acc_req_ready_o), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("no_late_rsp", 64'(bus.acc_rsp_valid_o), 64'd0);
            check_eq("no_late_dma", 64'(bus.dma_req_valid_o), 64'd0);
        end
        @(posedge clk); #1;
        run_op(K_CPYI, mk_op(K_CPYI, 5'd0, 5'd1, 5'd6), 32'd16, 32'd0, 5'd6, 0, 0, 32'd21);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
